// File: rtl/countah_state_reg_pkg.sv
// Shared encodings for the SPI multiplier control FSM: shift-register
// operation modes and the FSM state values held in the state register.
package countah_state_reg_pkg;

  // Shift-register operation modes, also used by the FSM's data shifters.
  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    PLOAD = 2'd3
  } mode_e;

  // FSM state encodings; zero is the idle state entered on reset.
  typedef enum logic [2:0] {
    ST_WAIT       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_MULT       = 3'd2,
    ST_MULTRES    = 3'd3,
    ST_MISORESULT = 3'd4
  } state_e;

  localparam int unsigned MODE_W = 2;

endpackage

// File: rtl/countah_state_reg_countah.sv
// Parameterised mode-controlled shift register. Used by the FSM as a
// one-hot bit counter: load a 1, then shift left once per SPI bit.
module countah
  import countah_state_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] parallelIn,
  input  logic             serialIn,
  output logic [WIDTH-1:0] parallelOut
);

  // Zero initialiser gives a defined value from time zero.
  logic [WIDTH-1:0] shreg_q = '0;
  logic [WIDTH-1:0] shreg_d;

  // Next value per mode; bits shifted off either end are discarded.
  always_comb begin
    shreg_d = shreg_q;
    case (mode)
      HOLD:    shreg_d = shreg_q;
      LEFT:    shreg_d = {shreg_q[WIDTH-2:0], serialIn};
      RIGHT:   shreg_d = {serialIn, shreg_q[WIDTH-1:1]};
      PLOAD:   shreg_d = parallelIn;
      default: shreg_d = shreg_q;
    endcase
  end

  // Register update; reset overrides every mode.
  always_ff @(posedge clk) begin
    if (reset) shreg_q <= '0;
    else       shreg_q <= shreg_d;
  end

  assign parallelOut = shreg_q;

endmodule

// File: rtl/countah_state_reg_registerDFFPARA.sv
// Parameterised write-enabled register holding the FSM state.
module registerDFFPARA #(
  parameter int unsigned STATE_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STATE_WIDTH-1:0] d,
  input  logic                   wrenable,
  output logic [STATE_WIDTH-1:0] q
);

  // Zero initialiser matches the idle state so simulation starts defined.
  logic [STATE_WIDTH-1:0] state_q = '0;
  logic [STATE_WIDTH-1:0] state_d;

  // Load the new state only when enabled, otherwise hold.
  always_comb begin
    state_d = state_q;
    if (wrenable) state_d = d;
  end

  // State flop; reset returns to the idle encoding.
  always_ff @(posedge clk) begin
    if (reset) state_q <= '0;
    else       state_q <= state_d;
  end

  assign q = state_q;

endmodule

// File: rtl/countah_state_reg.sv
// Sequencing storage for the SPI multiplier control FSM: a one-hot bit
// counter and the FSM state register, independent and sharing one clock.
module countah_state_reg
  import countah_state_reg_pkg::*;
#(
  parameter int unsigned WIDTH       = 9,
  parameter int unsigned STATE_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [MODE_W-1:0]      mode,
  input  logic [WIDTH-1:0]       parallelIn,
  input  logic                   serialIn,
  output logic [WIDTH-1:0]       parallelOut,
  input  logic [STATE_WIDTH-1:0] d,
  input  logic                   wrenable,
  output logic [STATE_WIDTH-1:0] q
);

  countah #(
    .WIDTH(WIDTH)
  ) u_countah (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .parallelIn  (parallelIn),
    .serialIn    (serialIn),
    .parallelOut (parallelOut)
  );

  registerDFFPARA #(
    .STATE_WIDTH(STATE_WIDTH)
  ) u_state (
    .clk      (clk),
    .reset    (reset),
    .d        (d),
    .wrenable (wrenable),
    .q        (q)
  );

endmodule

// File: tb/tb_countah_state_reg.sv
// Directed bench for countah_state_reg: counter modes, one-hot counting,
// state register enable, and reset priority.
module tb_countah_state_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [8:0] parallelIn;
  logic       serialIn;
  logic [8:0] parallelOut;
  logic [2:0] d;
  logic       wrenable;
  logic [2:0] q;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] M_HOLD = 2'd0, M_LEFT = 2'd1, M_RIGHT = 2'd2, M_PLOAD = 2'd3;

  countah_state_reg #(.WIDTH(9), .STATE_WIDTH(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .parallelIn  (parallelIn),
    .serialIn    (serialIn),
    .parallelOut (parallelOut),
    .d           (d),
    .wrenable    (wrenable),
    .q           (q)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_init();
    #1;
    checks++;
    if (parallelOut !== 9'h000) begin
      failures++;
      $display("FAIL init_count got=%h exp=%h", parallelOut, 9'h000);
    end
    checks++;
    if (q !== 3'd0) begin
      failures++;
      $display("FAIL init_state got=%0d exp=%0d", q, 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = M_PLOAD; parallelIn = 9'h1FF; serialIn = 1'b0;
    wrenable = 1'b0; d = 3'd0;
    step();
    checks++;
    if (parallelOut !== 9'h000) begin
      failures++;
      $display("FAIL reset_count got=%h exp=%h", parallelOut, 9'h000);
    end
    checks++;
    if (q !== 3'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=%0d", q, 0);
    end
    reset = 1'b0;
    step();
    checks++;
    if (parallelOut !== 9'h1FF) begin
      failures++;
      $display("FAIL reset_release_pload got=%h exp=%h", parallelOut, 9'h1FF);
    end
  endtask

  task automatic test_onehot();
    logic [8:0] exp;
    mode = M_PLOAD; parallelIn = 9'h001; serialIn = 1'b0;
    step();
    checks++;
    if (parallelOut !== 9'h001) begin
      failures++;
      $display("FAIL onehot_load got=%h exp=%h", parallelOut, 9'h001);
    end
    mode = M_LEFT;
    exp = 9'h001;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = exp << 1;
      checks++;
      if (parallelOut !== exp) begin
        failures++;
        $display("FAIL onehot_shift%0d got=%h exp=%h", k, parallelOut, exp);
      end
      checks++;
      if (parallelOut[8] !== (k == 8)) begin
        failures++;
        $display("FAIL onehot_msb%0d got=%b exp=%b", k, parallelOut[8], (k == 8));
      end
    end
    step();
    checks++;
    if (parallelOut !== 9'h000) begin
      failures++;
      $display("FAIL onehot_overflow got=%h exp=%h", parallelOut, 9'h000);
    end
  endtask

  task automatic test_hold_right();
    mode = M_PLOAD; parallelIn = 9'h0A5; serialIn = 1'b1;
    step();
    mode = M_HOLD;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (parallelOut !== 9'h0A5) begin
        failures++;
        $display("FAIL hold%0d got=%h exp=%h", i, parallelOut, 9'h0A5);
      end
    end
    mode = M_RIGHT;
    step();
    checks++;
    if (parallelOut !== 9'h152) begin
      failures++;
      $display("FAIL right_si1 got=%h exp=%h", parallelOut, 9'h152);
    end
    mode = M_LEFT;
    step();
    checks++;
    if (parallelOut !== 9'h0A5) begin
      failures++;
      $display("FAIL left_si1 got=%h exp=%h", parallelOut, 9'h0A5);
    end
  endtask

  task automatic test_state();
    mode = M_HOLD; serialIn = 1'b0;
    wrenable = 1'b1; d = 3'd1;
    step();
    checks++;
    if (q !== 3'd1) begin
      failures++;
      $display("FAIL state_write1 got=%0d exp=%0d", q, 1);
    end
    wrenable = 1'b0; d = 3'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (q !== 3'd1) begin
        failures++;
        $display("FAIL state_hold%0d got=%0d exp=%0d", i, q, 1);
      end
    end
    checks++;
    if (parallelOut !== 9'h0A5) begin
      failures++;
      $display("FAIL state_counter_indep got=%h exp=%h", parallelOut, 9'h0A5);
    end
    wrenable = 1'b1;
    step();
    checks++;
    if (q !== 3'd4) begin
      failures++;
      $display("FAIL state_write4 got=%0d exp=%0d", q, 4);
    end
    wrenable = 1'b0;
  endtask

  task automatic test_back_to_back();
    mode = M_PLOAD; parallelIn = 9'h155; wrenable = 1'b1; d = 3'd2;
    step();
    checks++;
    if (parallelOut !== 9'h155 || q !== 3'd2) begin
      failures++;
      $display("FAIL b2b_same_edge got=%h/%0d exp=%h/%0d", parallelOut, q, 9'h155, 2);
    end
    mode = M_LEFT; serialIn = 1'b0; d = 3'd3;
    step();
    checks++;
    if (parallelOut !== 9'h0AA || q !== 3'd3) begin
      failures++;
      $display("FAIL b2b_next_edge got=%h/%0d exp=%h/%0d", parallelOut, q, 9'h0AA, 3);
    end
    wrenable = 1'b0;
  endtask

  task automatic test_reset_priority();
    mode = M_LEFT; serialIn = 1'b1;
    reset = 1'b1; wrenable = 1'b1; d = 3'd3;
    step();
    checks++;
    if (parallelOut !== 9'h000) begin
      failures++;
      $display("FAIL rstprio_count got=%h exp=%h", parallelOut, 9'h000);
    end
    checks++;
    if (q !== 3'd0) begin
      failures++;
      $display("FAIL rstprio_state got=%0d exp=%0d", q, 0);
    end
    reset = 1'b0; wrenable = 1'b0;
  endtask

  task automatic test_mid_reset();
    mode = M_PLOAD; parallelIn = 9'h001; serialIn = 1'b0;
    step();
    mode = M_LEFT;
    repeat (4) step();
    checks++;
    if (parallelOut !== 9'h010) begin
      failures++;
      $display("FAIL midrst_pre got=%h exp=%h", parallelOut, 9'h010);
    end
    reset = 1'b1;
    step();
    checks++;
    if (parallelOut !== 9'h000) begin
      failures++;
      $display("FAIL midrst_clear got=%h exp=%h", parallelOut, 9'h000);
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (parallelOut !== 9'h000) begin
        failures++;
        $display("FAIL midrst_after%0d got=%h exp=%h", i, parallelOut, 9'h000);
      end
    end
  endtask

  initial begin
    reset = 1'b0; mode = M_HOLD; parallelIn = '0; serialIn = 1'b0;
    d = '0; wrenable = 1'b0;
    test_init();
    test_reset();
    test_onehot();
    test_hold_right();
    test_state();
    test_back_to_back();
    test_reset_priority();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
